// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: scans DIGITS digits with dead time,
// frame-coherent input snapshot, blink, leading-zero suppression and decimal points.
module seg7_scan_driver #(
    parameter int DIGITS    = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int DEAD      = 2,
    parameter int BLINK_DIV = 25000000,
    parameter int HEX       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  lzs_en,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT   = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         blink_cnt;
    logic                  phase;
    logic [4*DIGITS-1:0]   sh_bcd;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blink;

    logic                  slot_end;
    logic                  wrap;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;
    logic [DIGITS-1:0]     lz;
    logic                  lead;
    logic                  blink_off;
    logic                  seg_off;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            4'd10:   g = (HEX != 0) ? 7'b0001000 : 7'b1111111;
            4'd11:   g = (HEX != 0) ? 7'b0000011 : 7'b1111111;
            4'd12:   g = (HEX != 0) ? 7'b1000110 : 7'b1111111;
            4'd13:   g = (HEX != 0) ? 7'b0100001 : 7'b1111111;
            4'd14:   g = (HEX != 0) ? 7'b0000110 : 7'b1111111;
            default: g = (HEX != 0) ? 7'b0001110 : 7'b1111111;
        endcase
        return g;
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lead = 1'b1;
        lz   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead  = lead & (sh_bcd[4*i +: 4] == 4'd0);
            lz[i] = lead & (i != 0);
        end
    end

    always_comb begin
        cur_code  = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = sh_bcd[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blink = sh_blink[i];
                cur_lz    = lz[i];
            end
        end
    end

    assign blink_off = phase & cur_blink;
    assign seg_off   = blink_off | (lzs_en & cur_lz) | ~en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            sh_bcd     <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            frame_tick <= 1'b0;
            seg_n      <= 7'b1111111;
            dp_n       <= 1'b1;
            an_n       <= '1;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (wrap) begin
                sh_bcd   <= bcd_in;
                sh_dp    <= dp_in;
                sh_blink <= blink_mask;
            end
            frame_tick <= wrap;

            an_n  <= (en && (cnt >= DEAD_CNT)) ? ~(DIGITS'(1) << idx) : '1;
            seg_n <= seg_off ? 7'b1111111 : decode(cur_code);
            dp_n  <= (blink_off || !en) ? 1'b1 : ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_DIV=64,
// one instance with hex glyphs and one without.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        lzs_en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;
    logic [6:0]  seg_n0;
    logic        dp_n0;
    logic [3:0]  an_n0;
    logic        frame_tick0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .BLINK_DIV(64), .HEX(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lzs_en(lzs_en), .bcd_in(bcd_in),
        .dp_in(dp_in), .blink_mask(blink_mask), .seg_n(seg_n), .dp_n(dp_n),
        .an_n(an_n), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .BLINK_DIV(64), .HEX(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .en(en), .lzs_en(lzs_en), .bcd_in(bcd_in),
        .dp_in(dp_in), .blink_mask(blink_mask), .seg_n(seg_n0), .dp_n(dp_n0),
        .an_n(an_n0), .frame_tick(frame_tick0)
    );

    // clock / reset-aligned edge counter
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_dark(input string name);
        n_cmp++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: an_n=%b seg_n=%b dp_n=%b tick=%b required 1111 1111111 1 0",
                     name, an_n, seg_n, dp_n, frame_tick);
        end
    endtask

    task automatic wait_tick();
        int n;
        @(negedge clk);
        n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_tick: frame_tick=%b required 1 within 100 cycles", frame_tick);
        end
    endtask

    // Starts on the frame_tick cycle, checks cycles 1..31 of the frame, ends on the next tick.
    task automatic check_frame(input string name, input logic [3:0][6:0] exp_seg,
                               input logic [3:0] exp_dpn, input logic [3:0] blink_sel,
                               input int change_k, input logic [15:0] new_bcd);
        int s, c, d;
        logic ph;
        logic [3:0] ea;
        logic [6:0] es;
        logic edp;
        ph = ((cyc / 64) % 2) == 1;
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            s = k / 8;
            c = k % 8;
            if (c == 1 || c == 2) begin
                n_cmp++;
                if (an_n !== 4'hF) begin
                    n_fail++;
                    $display("FAIL %s dead k=%0d: an_n=%b required 1111", name, k, an_n);
                end
            end else begin
                d   = (c == 0) ? s - 1 : s;
                ea  = ~(4'b0001 << d);
                es  = (ph && blink_sel[d]) ? 7'b1111111 : exp_seg[d];
                edp = (ph && blink_sel[d]) ? 1'b1 : exp_dpn[d];
                n_cmp++;
                if (an_n !== ea || seg_n !== es || dp_n !== edp) begin
                    n_fail++;
                    $display("FAIL %s k=%0d: an_n=%b seg_n=%b dp_n=%b required %b %b %b",
                             name, k, an_n, seg_n, dp_n, ea, es, edp);
                end
            end
            n_cmp++;
            if (frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL %s tick k=%0d: frame_tick=%b required 0", name, k, frame_tick);
            end
            if (k == change_k) bcd_in = new_bcd;
        end
        @(negedge clk);
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL %s period: frame_tick=%b required 1 after 32 clocks", name, frame_tick);
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 1'b1; lzs_en = 1'b0; bcd_in = 16'h1234;
        dp_in = 4'h0; blink_mask = 4'h0;
        #12;
        check_dark("reset_por");
        n_cmp++;
        if (an_n0 !== 4'hF || seg_n0 !== 7'h7F || dp_n0 !== 1'b1 || frame_tick0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_por_h0: an_n=%b seg_n=%b dp_n=%b required 1111 1111111 1",
                     an_n0, seg_n0, dp_n0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (an_n !== 4'b1110 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (an_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_reach_slot0: an_n=%b required 1110", an_n);
        end
        #2 rst_n = 1'b0;
        #1 check_dark("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_cmp++;
                if (an_n !== 4'hF) begin
                    n_fail++;
                    $display("FAIL reset_dead: an_n=%b required 1111", an_n);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (an_n !== 4'b1110 || seg_n !== 7'b1000000) begin
                    n_fail++;
                    $display("FAIL reset_restart: an_n=%b seg_n=%b required 1110 1000000", an_n, seg_n);
                end
            end
            if (k == 31 || k == 32) begin
                n_cmp++;
                if (frame_tick !== (k == 32)) begin
                    n_fail++;
                    $display("FAIL reset_first_tick k=%0d: frame_tick=%b required %b",
                             k, frame_tick, (k == 32));
                end
            end
        end
    endtask

    task automatic test_basic();
        bcd_in = 16'h1234; lzs_en = 1'b0; dp_in = 4'h0; blink_mask = 4'h0;
        wait_tick();
        check_frame("basic_1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                    4'b1111, 4'b0000, -1, 16'h0);
    endtask

    task automatic test_lzs();
        bcd_in = 16'h0070; lzs_en = 1'b1;
        wait_tick();
        check_frame("lzs_on", {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000},
                    4'b1111, 4'b0000, -1, 16'h0);
        lzs_en = 1'b0;
        check_frame("lzs_off", {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000},
                    4'b1111, 4'b0000, -1, 16'h0);
    endtask

    task automatic test_hex();
        bcd_in = 16'h000A; lzs_en = 1'b0;
        wait_tick();
        check_frame("hex1_A", {7'b1000000, 7'b1000000, 7'b1000000, 7'b0001000},
                    4'b1111, 4'b0000, -1, 16'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4 || k == 12) begin
                n_cmp++;
                if (seg_n0 !== ((k == 4) ? 7'b1111111 : 7'b1000000) || an_n0 !== an_n) begin
                    n_fail++;
                    $display("FAIL hex0_blank k=%0d: seg_n=%b an_n=%b required %b %b", k, seg_n0,
                             an_n0, (k == 4) ? 7'b1111111 : 7'b1000000, an_n);
                end
            end
        end
    endtask

    task automatic test_blink();
        bcd_in = 16'h0008; dp_in = 4'b0001; blink_mask = 4'b0001; lzs_en = 1'b0;
        wait_tick();
        for (int f = 0; f < 4; f++)
            check_frame("blink", {7'b1000000, 7'b1000000, 7'b1000000, 7'b0000000},
                        4'b1110, 4'b0001, -1, 16'h0);
    endtask

    task automatic test_snapshot();
        bcd_in = 16'h1111; dp_in = 4'h0; blink_mask = 4'h0;
        wait_tick();
        check_frame("snap_old", {4{7'b1111001}}, 4'b1111, 4'b0000, 12, 16'h2222);
        check_frame("snap_new", {4{7'b0100100}}, 4'b1111, 4'b0000, -1, 16'h0);
    endtask

    task automatic test_enable();
        bcd_in = 16'h1234;
        wait_tick();
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_dark("enable_off");
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (an_n !== 4'b1110 || seg_n !== 7'b0011001) begin
            n_fail++;
            $display("FAIL enable_on: an_n=%b seg_n=%b required 1110 0011001", an_n, seg_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lzs();
        test_hex();
        test_blink();
        test_snapshot();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
